// File: rtl/ms_delay_timer.sv
// ms_delay_timer: wrap-safe one-shot millisecond delay timer with start/busy/done handshake.
// Define DELAY_TIMER_PERIODIC_EN to add input `periodic` for drift-free periodic re-arming.
module ms_delay_timer #(
  parameter int TW = 32,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] time_ms,
  input  logic          start,
  input  logic [DW-1:0] dur_ms,
  input  logic          cancel,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] remaining
`ifdef DELAY_TIMER_PERIODIC_EN
  ,
  input  logic          periodic
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIRE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [TW-1:0] stamp_r;
  logic [TW-1:0] stamp_next_s;
  logic [DW-1:0] dur_r;
  logic [DW-1:0] dur_next_s;
  logic          periodic_r;
  logic          periodic_next_s;
  logic          periodic_req_s;
  logic [TW-1:0] elapsed_s;
  logic          expired_s;
  logic [TW-1:0] elapsed_next_s;
  logic          busy_r;
  logic          done_r;
  logic [DW-1:0] remaining_r;
  logic          busy_next_s;
  logic          done_next_s;
  logic [DW-1:0] remaining_next_s;

`ifdef DELAY_TIMER_PERIODIC_EN
  assign periodic_req_s = periodic;
`else
  assign periodic_req_s = 1'b0;
`endif

  // Modular subtraction keeps the comparison correct across time_ms wrap;
  // a backwards jump of time_ms yields a huge elapsed and expires at once.
  assign elapsed_s = time_ms - stamp_r;
  assign expired_s = (elapsed_s >= TW'(dur_r));

  // Next-state and next-output logic; priority cancel > start > expiry
  always_comb begin
    next_state_s     = state_r;
    stamp_next_s     = stamp_r;
    dur_next_s       = dur_r;
    periodic_next_s  = periodic_r;
    busy_next_s      = 1'b0;
    done_next_s      = 1'b0;
    remaining_next_s = {DW{1'b0}};
    elapsed_next_s   = {TW{1'b0}};

    if (cancel) begin
      next_state_s    = ST_IDLE;
      periodic_next_s = 1'b0;
    end else if (start) begin
      if (dur_ms != {DW{1'b0}}) begin
        next_state_s    = ST_RUN;
        stamp_next_s    = time_ms;
        dur_next_s      = dur_ms;
        periodic_next_s = periodic_req_s;
      end else begin
        // A zero delay completes immediately and is never periodic.
        next_state_s    = ST_FIRE;
        dur_next_s      = {DW{1'b0}};
        periodic_next_s = 1'b0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          next_state_s = ST_IDLE;
        end
        ST_RUN: begin
          if (expired_s) begin
            next_state_s = ST_FIRE;
            if (periodic_r) begin
              stamp_next_s = stamp_r + TW'(dur_r);
            end else begin
              stamp_next_s = stamp_r;
            end
          end else begin
            next_state_s = ST_RUN;
          end
        end
        ST_FIRE: begin
          if (periodic_r) begin
            next_state_s = ST_RUN;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        default: begin
          next_state_s    = ST_IDLE;
          periodic_next_s = 1'b0;
        end
      endcase
    end

    elapsed_next_s = time_ms - stamp_next_s;
    done_next_s    = (next_state_s == ST_FIRE);
    busy_next_s    = (next_state_s == ST_RUN) ||
                     ((next_state_s == ST_FIRE) && periodic_next_s);
    if ((next_state_s == ST_RUN) && (elapsed_next_s < TW'(dur_next_s))) begin
      remaining_next_s = dur_next_s - DW'(elapsed_next_s);
    end else begin
      remaining_next_s = {DW{1'b0}};
    end
  end

  // State, timing context and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      stamp_r     <= {TW{1'b0}};
      dur_r       <= {DW{1'b0}};
      periodic_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      remaining_r <= {DW{1'b0}};
    end else begin
      state_r     <= next_state_s;
      stamp_r     <= stamp_next_s;
      dur_r       <= dur_next_s;
      periodic_r  <= periodic_next_s;
      busy_r      <= busy_next_s;
      done_r      <= done_next_s;
      remaining_r <= remaining_next_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign remaining = remaining_r;

endmodule

// ms_delay_timer_chk: output invariants of ms_delay_timer, instantiated alongside it.
module ms_delay_timer_chk #(
  parameter int DW = 16
) (
  input logic          clk,
  input logic          rst,
  input logic          busy,
  input logic          done,
  input logic [DW-1:0] remaining
);

  a_idle_rem_zero: assert property (@(posedge clk) disable iff (!rst)
    !busy |-> (remaining == {DW{1'b0}}));

  a_done_rem_zero: assert property (@(posedge clk) disable iff (!rst)
    done |-> (remaining == {DW{1'b0}}));

`ifndef DELAY_TIMER_PERIODIC_EN
  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst)
    done |-> !busy);
`endif

endmodule

// File: tb/tb_ms_delay_timer.sv
// tb_ms_delay_timer: directed vector table plus randomized run against a behavioural model.
// The periodic sequence runs only when DELAY_TIMER_PERIODIC_EN is defined.
`timescale 1ns/1ps
module tb_ms_delay_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] time_ms = 32'd0;
  logic        start = 1'b0;
  logic [15:0] dur_ms = 16'd0;
  logic        cancel = 1'b0;
  logic        per_in = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] remaining;

  int checks = 0;
  int errors = 0;

  ms_delay_timer #(.TW(32), .DW(16)) dut (
    .clk(clk), .rst(rst), .time_ms(time_ms), .start(start), .dur_ms(dur_ms),
    .cancel(cancel), .busy(busy), .done(done), .remaining(remaining)
`ifdef DELAY_TIMER_PERIODIC_EN
    , .periodic(per_in)
`endif
  );

  ms_delay_timer_chk #(.DW(16)) u_chk (
    .clk(clk), .rst(rst), .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  // Reference model: a pending deadline (t0 + d) plus a one-cycle firing flag.
  bit          m_wait, m_fire, m_per;
  logic [31:0] m_t0, m_d;
  bit          exp_busy, exp_done;
  logic [15:0] exp_rem;

  task automatic model_reset();
    m_wait = 0; m_fire = 0; m_per = 0; m_t0 = 32'd0; m_d = 32'd0;
  endtask

  task automatic model_step(input logic [31:0] t, input bit st, input logic [15:0] d,
                            input bit cn, input bit p);
    bit was_fire;
    logic [31:0] el;
    logic [31:0] r;
    was_fire = m_fire;
    m_fire = 0;
    if (cn) begin
      m_wait = 0; m_per = 0;
    end else if (st) begin
      if (d != 16'd0) begin
        m_wait = 1; m_t0 = t; m_d = {16'd0, d}; m_per = p;
      end else begin
        m_wait = 0; m_fire = 1; m_per = 0;
      end
    end else if (m_wait) begin
      if ((t - m_t0) >= m_d) begin
        m_wait = 0; m_fire = 1;
        if (m_per) m_t0 = m_t0 + m_d;
      end
    end else if (was_fire && m_per) begin
      m_wait = 1;
    end
    el = t - m_t0;
    r = m_d - el;
    exp_done = m_fire;
    exp_busy = m_wait || (m_fire && m_per);
    exp_rem  = (m_wait && (el < m_d)) ? r[15:0] : 16'd0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one clock edge worth of inputs; returns 1ns after the edge.
  task automatic cycle(input logic [31:0] t, input bit st, input logic [15:0] d,
                       input bit cn, input bit p);
    time_ms = t; start = st; dur_ms = d; cancel = cn; per_in = p;
    @(posedge clk);
    model_step(t, st, d, cn, p);
    #1;
  endtask

  typedef struct {
    logic [31:0] t;
    bit          st;
    logic [15:0] dur;
    bit          cn;
    bit          eb;
    bit          ed;
    logic [15:0] er;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [31:0] t, input bit st, input logic [15:0] dur,
                              input bit cn, input bit eb, input bit ed, input logic [15:0] er);
    vec_t v;
    v.t = t; v.st = st; v.dur = dur; v.cn = cn; v.eb = eb; v.ed = ed; v.er = er;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] cur_t;
    int          n_done;
    int          r;
    bit          st;
    bit          cn;
    logic [15:0] d;

    model_reset();
    // Basic delay: start at 100 for 5 ms
    add(32'd100, 1, 16'd5, 0, 1, 0, 16'd5);
    add(32'd101, 0, 16'd0, 0, 1, 0, 16'd4);
    add(32'd102, 0, 16'd0, 0, 1, 0, 16'd3);
    add(32'd103, 0, 16'd0, 0, 1, 0, 16'd2);
    add(32'd104, 0, 16'd0, 0, 1, 0, 16'd1);
    add(32'd105, 0, 16'd0, 0, 0, 1, 16'd0);
    add(32'd106, 0, 16'd0, 0, 0, 0, 16'd0);
    // Zero delay, then cancel with start in the same cycle
    add(32'd200, 1, 16'd0, 0, 0, 1, 16'd0);
    add(32'd200, 0, 16'd0, 0, 0, 0, 16'd0);
    add(32'd200, 1, 16'd7, 1, 0, 0, 16'd0);
    // Cancel mid-run
    add(32'd0,   1, 16'd10, 0, 1, 0, 16'd10);
    add(32'd3,   0, 16'd0,  0, 1, 0, 16'd7);
    add(32'd6,   0, 16'd0,  1, 0, 0, 16'd0);
    add(32'd12,  0, 16'd0,  0, 0, 0, 16'd0);
    // Restart mid-run
    add(32'd0,   1, 16'd10, 0, 1, 0, 16'd10);
    add(32'd5,   1, 16'd3,  0, 1, 0, 16'd3);
    add(32'd7,   0, 16'd0,  0, 1, 0, 16'd1);
    add(32'd8,   0, 16'd0,  0, 0, 1, 16'd0);
    add(32'd9,   0, 16'd0,  0, 0, 0, 16'd0);
    add(32'd10,  0, 16'd0,  0, 0, 0, 16'd0);
    // time_ms wrap
    add(32'hFFFF_FFFE, 1, 16'd4, 0, 1, 0, 16'd4);
    add(32'hFFFF_FFFF, 0, 16'd0, 0, 1, 0, 16'd3);
    add(32'h0000_0000, 0, 16'd0, 0, 1, 0, 16'd2);
    add(32'h0000_0001, 0, 16'd0, 0, 1, 0, 16'd1);
    add(32'h0000_0002, 0, 16'd0, 0, 0, 1, 16'd0);
    add(32'h0000_0003, 0, 16'd0, 0, 0, 0, 16'd0);
    // time_ms jumps backwards
    add(32'd1000, 1, 16'd50, 0, 1, 0, 16'd50);
    add(32'd10,   0, 16'd0,  0, 0, 1, 16'd0);
    add(32'd11,   0, 16'd0,  0, 0, 0, 16'd0);
    // Start accepted while firing
    add(32'd500, 1, 16'd0, 0, 0, 1, 16'd0);
    add(32'd500, 1, 16'd2, 0, 1, 0, 16'd2);
    add(32'd501, 0, 16'd0, 0, 1, 0, 16'd1);
    add(32'd502, 0, 16'd0, 0, 0, 1, 16'd0);
    add(32'd503, 0, 16'd0, 0, 0, 0, 16'd0);

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.rem", {16'd0, remaining}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].t, vecs[i].st, vecs[i].dur, vecs[i].cn, 1'b0);
      check($sformatf("vec%0d.busy", i), {31'd0, busy}, {31'd0, vecs[i].eb});
      check($sformatf("vec%0d.done", i), {31'd0, done}, {31'd0, vecs[i].ed});
      check($sformatf("vec%0d.rem", i), {16'd0, remaining}, {16'd0, vecs[i].er});
    end

    // Asynchronous reset in the middle of a delay; start during reset is lost
    cycle(32'd1000, 1, 16'd20, 0, 0);
    cycle(32'd1001, 0, 16'd0, 0, 0);
    check("pre_arst.busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst.busy", {31'd0, busy}, 32'd0);
    check("arst.rem", {16'd0, remaining}, 32'd0);
    model_reset();
    start = 1'b1; dur_ms = 16'd5;
    @(posedge clk);
    #1 rst = 1'b1;
    cycle(32'd1002, 0, 16'd0, 0, 0);
    check("post_rst.busy", {31'd0, busy}, 32'd0);
    check("post_rst.done", {31'd0, done}, 32'd0);

    // Randomized run against the model
    cur_t = 32'd5000;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      cur_t = cur_t;
      else if (r < 94) cur_t = cur_t + 32'd1;
      else if (r < 96) cur_t = cur_t + $urandom_range(2, 30);
      else if (r < 98) cur_t = 32'hFFFF_FFF0 + $urandom_range(0, 10);
      else             cur_t = cur_t - $urandom_range(1, 1000);
      st = ($urandom_range(0, 15) == 0);
      cn = ($urandom_range(0, 31) == 0);
      if (m_wait) d = 16'($urandom_range(1, 40));
      else        d = 16'($urandom_range(0, 40));
      cycle(cur_t, st, d, cn, 1'b0);
      check($sformatf("rnd%0d.busy", i), {31'd0, busy}, {31'd0, exp_busy});
      check($sformatf("rnd%0d.done", i), {31'd0, done}, {31'd0, exp_done});
      check($sformatf("rnd%0d.rem", i), {16'd0, remaining}, {16'd0, exp_rem});
    end

`ifdef DELAY_TIMER_PERIODIC_EN
    // Periodic: dur 4 from t=0 fires at 4, 8, 12 and holds busy until cancelled
    cycle(32'd0, 0, 16'd0, 1, 0);
    cycle(32'd0, 1, 16'd4, 0, 1);
    n_done = 0;
    for (int t = 1; t <= 13; t++) begin
      cycle(32'(t), 0, 16'd0, 0, 1);
      if (done) n_done++;
      check($sformatf("per_t%0d.done", t), {31'd0, done}, {31'd0, ((t % 4) == 0)});
      check($sformatf("per_t%0d.busy", t), {31'd0, busy}, 32'd1);
      check($sformatf("per_t%0d.rem", t), {16'd0, remaining}, {16'd0, exp_rem});
    end
    check("per.count", n_done, 32'd3);
    cycle(32'd14, 0, 16'd0, 1, 1);
    check("per.cancel.busy", {31'd0, busy}, 32'd0);
    cycle(32'd16, 0, 16'd0, 0, 1);
    check("per.cancel.done", {31'd0, done}, 32'd0);
`else
    n_done = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
